quacker_cfg_writer: RTL

//  AXI4-Lite write sequencer that programs the quacker peripheral's slave register bank (S00_AXI).
//  One start pulse issues up to C_NUM_REGS single-beat writes to C_BASE_ADDR + 4*i, in ascending

---
 rtl/quacker_pkg.sv | 24 ++
 rtl/quacker_cfg_writer_if.sv | 27 ++
 rtl/quacker_next_idx.sv | 24 ++
 rtl/quacker_cfg_writer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/quacker_pkg.sv
// Shared constants and types for the quacker configuration writer.
// AXI response codes, register stride and the sequencer state encoding.
package quacker_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int REG_STRIDE = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RESP,
      ST_DONE
   } state_t;

   // Byte offset of register idx inside the quacker slave register bank.
   function automatic logic [31:0] reg_offset(input logic [2:0] idx);
      return 32'(idx) * 32'(REG_STRIDE);
   endfunction

endpackage

// File: rtl/quacker_cfg_writer_if.sv
// AXI4-Lite write-only channel bundle between the writer (master) and quacker S00_AXI (slave).
interface quacker_cfg_writer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/quacker_next_idx.sv
// Priority scan for the lowest set mask bit, either from bit 0 or strictly above cur_idx.
module quacker_next_idx #(
   parameter int NUM_REGS = 4
) (
   input  logic [NUM_REGS-1:0] mask,
   input  logic [2:0]          cur_idx,
   input  logic                from_start,
   output logic [2:0]          next_idx,
   output logic                found
);

   // Scanning downward lets the lowest qualifying bit win.
   always_comb begin
      next_idx = '0;
      found    = 1'b0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (mask[i] && (from_start || (i > int'(cur_idx)))) begin
            next_idx = 3'(i);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/quacker_cfg_writer.sv
// Sequencer that writes a masked set of quacker registers over AXI4-Lite, one beat per register,
// checking each write response and aborting on the first non-OKAY reply.
module quacker_cfg_writer
   import quacker_pkg::*;
#(
   parameter logic [31:0] C_BASE_ADDR  = 32'h43C0_0000,
   parameter int          C_NUM_REGS   = 4,
   parameter int          C_ADDR_WIDTH = 32,
   parameter int          C_DATA_WIDTH = 32
) (
   input  logic                               ACLK,
   input  logic                               ARESET,
   input  logic                               start,
   input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] cfg_data,
   input  logic [C_NUM_REGS-1:0]              cfg_mask,
   output logic                               busy,
   output logic                               done,
   output logic                               err,
   output logic [2:0]                         err_idx,
   quacker_cfg_writer_if.master               m_axi
);

   state_t                             state;
   logic [2:0]                         idx;
   logic [C_NUM_REGS-1:0]              mask_q;
   logic [C_NUM_REGS*C_DATA_WIDTH-1:0] data_q;
   logic                               aw_done;
   logic                               w_done;
   logic [C_ADDR_WIDTH-1:0]            awaddr_q;
   logic [C_DATA_WIDTH-1:0]            wdata_q;
   logic                               awvalid_q;
   logic                               wvalid_q;
   logic                               bready_q;

   logic [C_NUM_REGS-1:0]              scan_mask;
   logic [C_NUM_REGS*C_DATA_WIDTH-1:0] scan_data;
   logic [2:0]                         nxt;
   logic                               nxt_found;
   logic [C_ADDR_WIDTH-1:0]            nxt_addr;
   logic [C_DATA_WIDTH-1:0]            nxt_data;
   logic                               aw_hs;
   logic                               w_hs;
   logic                               b_hs;

   // In IDLE the scan looks at the live inputs; afterwards at the latched copy.
   assign scan_mask = (state == ST_IDLE) ? cfg_mask : mask_q;
   assign scan_data = (state == ST_IDLE) ? cfg_data : data_q;
   assign nxt_addr  = C_ADDR_WIDTH'(C_BASE_ADDR) + C_ADDR_WIDTH'(reg_offset(nxt));
   assign nxt_data  = scan_data[C_DATA_WIDTH*int'(nxt) +: C_DATA_WIDTH];

   assign aw_hs = awvalid_q & m_axi.awready;
   assign w_hs  = wvalid_q & m_axi.wready;
   assign b_hs  = bready_q & m_axi.bvalid;

   quacker_next_idx #(
      .NUM_REGS (C_NUM_REGS)
   ) u_next_idx (
      .mask       (scan_mask),
      .cur_idx    (idx),
      .from_start (state == ST_IDLE),
      .next_idx   (nxt),
      .found      (nxt_found)
   );

   assign m_axi.awaddr  = awaddr_q;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = '1;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = bready_q;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state     <= ST_IDLE;
         idx       <= '0;
         mask_q    <= '0;
         data_q    <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_idx   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mask_q  <= cfg_mask;
                  data_q  <= cfg_data;
                  err     <= 1'b0;
                  err_idx <= '0;
                  if (nxt_found) begin
                     idx       <= nxt;
                     awaddr_q  <= nxt_addr;
                     wdata_q   <= nxt_data;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done   <= 1'b0;
                     w_done    <= 1'b0;
                     busy      <= 1'b1;
                     state     <= ST_ISSUE;
                  end else begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end
               end
            end

            // Address and data channels complete independently, in either order.
            ST_ISSUE: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done   <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done   <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  bready_q <= 1'b1;
                  state    <= ST_RESP;
               end
            end

            ST_RESP: begin
               if (b_hs) begin
                  bready_q <= 1'b0;
                  if (m_axi.bresp != RESP_OKAY) begin
                     err     <= 1'b1;
                     err_idx <= idx;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state   <= ST_DONE;
                  end else if (nxt_found) begin
                     idx       <= nxt;
                     awaddr_q  <= nxt_addr;
                     wdata_q   <= nxt_data;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done   <= 1'b0;
                     w_done    <= 1'b0;
                     state     <= ST_ISSUE;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
